hex_msg_scroller: RTL

- Parametrised successor to the fixed 6-digit "dE1" ticker. Scrolls a runtime-loadable message of up to MSG_MAX characters across NUM_DIGITS active-low 7-segment displays.
- Message length, direction, run/pause and single-step are all controlled at runtime.
- Owns its own rate prescaler, so no external enable counter is needed. Drives the HEX bus directly from the board top level.

---
 rtl/hex_msg_scroller_if.sv | 39 +++
 rtl/hex_msg_scroller.sv | 131 +++++++++++++
 2 files changed

// File: rtl/hex_msg_scroller_if.sv
// hex_msg_scroller_if
//   Control, message-write and display bundle for hex_msg_scroller.
//   master : run/dir/step control, msg_len, buffer write port; observes outputs
//   slave  : the scroller; drives hex_out, pos, tick, wrap
//   Signals:
//     run, dir, step        scroll control (step is a one-cycle pulse)
//     msg_len [AW:0]        active message length (0 -> 1, > MSG_MAX -> MSG_MAX)
//     wr_en/wr_addr/wr_data message buffer write port (5-bit character codes)
//     hex_out               NUM_DIGITS x 7 active-low segments, gfedcba per digit
//     pos                   message index on the leftmost digit
//     tick, wrap            one-cycle status pulses
interface hex_msg_scroller_if #(
   parameter int NUM_DIGITS = 6,
   parameter int MSG_MAX    = 16
);
   localparam int AW = $clog2(MSG_MAX);

   logic                    run;
   logic                    dir;
   logic                    step;
   logic [AW:0]             msg_len;
   logic                    wr_en;
   logic [AW-1:0]           wr_addr;
   logic [4:0]              wr_data;
   logic [7*NUM_DIGITS-1:0] hex_out;
   logic [AW-1:0]           pos;
   logic                    tick;
   logic                    wrap;

   modport master (
      output run, dir, step, msg_len, wr_en, wr_addr, wr_data,
      input  hex_out, pos, tick, wrap
   );

   modport slave (
      input  run, dir, step, msg_len, wr_en, wr_addr, wr_data,
      output hex_out, pos, tick, wrap
   );
endinterface

// File: rtl/hex_msg_scroller.sv
// hex_msg_scroller
//   Scrolls a runtime-loadable message of up to MSG_MAX characters across
//   NUM_DIGITS active-low 7-segment digits, with its own rate prescaler.
//   Ports:
//     clk_i     system clock
//     resetn_i  synchronous active-low reset
//     bus       hex_msg_scroller_if.slave (control, buffer write, display/status)
module hex_msg_scroller #(
   parameter int NUM_DIGITS = 6,
   parameter int MSG_MAX    = 16,
   parameter int TICK_DIV   = 50_000_000
) (
   input  logic                 clk_i,
   input  logic                 resetn_i,
   hex_msg_scroller_if.slave    bus
);
   localparam int AW = $clog2(MSG_MAX);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [4:0] BLANK = 5'h10;

   function automatic logic [6:0] seg7(input logic [4:0] c);
      case (c)
         5'h00: seg7 = 7'b1000000;
         5'h01: seg7 = 7'b1111001;
         5'h02: seg7 = 7'b0100100;
         5'h03: seg7 = 7'b0110000;
         5'h04: seg7 = 7'b0011001;
         5'h05: seg7 = 7'b0010010;
         5'h06: seg7 = 7'b0000010;
         5'h07: seg7 = 7'b1111000;
         5'h08: seg7 = 7'b0000000;
         5'h09: seg7 = 7'b0010000;
         5'h0A: seg7 = 7'b0001000;
         5'h0B: seg7 = 7'b0000011;
         5'h0C: seg7 = 7'b1000110;
         5'h0D: seg7 = 7'b0100001;
         5'h0E: seg7 = 7'b0000110;
         5'h0F: seg7 = 7'b0001110;
         5'h11: seg7 = 7'b0001001;   // H
         5'h12: seg7 = 7'b1000111;   // L
         5'h13: seg7 = 7'b0001100;   // P
         5'h14: seg7 = 7'b0111111;   // '-'
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   logic [4:0]              buf_q [MSG_MAX];
   logic [AW-1:0]           pos_q, pos_d;
   logic [PW-1:0]           cnt_q;
   logic                    tick_q, wrap_q, wrap_d;
   logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

   logic [AW:0] len_eff, last, pos_ext, disp_idx;
   logic        expire, adv, shrink;

   always_comb begin
      if (bus.msg_len == '0)
         len_eff = (AW+1)'(1);
      else if (bus.msg_len > (AW+1)'(MSG_MAX))
         len_eff = (AW+1)'(MSG_MAX);
      else
         len_eff = bus.msg_len;
   end

   assign last    = len_eff - 1'b1;
   assign pos_ext = {1'b0, pos_q};
   assign expire  = (cnt_q == PW'(TICK_DIV-1));
   // While running only the prescaler advances; step matters only when paused.
   assign adv     = bus.run ? expire : bus.step;
   assign shrink  = (pos_ext >= len_eff);

   always_comb begin
      pos_d  = pos_q;
      wrap_d = 1'b0;
      if (shrink) begin
         pos_d = '0;                          // silent recentre, no wrap pulse
      end else if (adv) begin
         if (!bus.dir) begin
            if (pos_ext == last) begin
               pos_d  = '0;
               wrap_d = 1'b1;
            end else begin
               pos_d = pos_q + 1'b1;
            end
         end else begin
            if (pos_q == '0) begin
               pos_d  = last[AW-1:0];
               wrap_d = 1'b1;
            end else begin
               pos_d = pos_q - 1'b1;
            end
         end
      end
   end

   // Walk the message from the leftmost digit rightwards, wrapping at L.
   // This replaces a (pos+j) mod L divider with a chain of compares.
   always_comb begin
      hex_d    = '1;
      disp_idx = shrink ? '0 : pos_ext;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         hex_d[7*(NUM_DIGITS-1-j) +: 7] = seg7(buf_q[disp_idx[AW-1:0]]);
         disp_idx = (disp_idx == last) ? '0 : disp_idx + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         for (int k = 0; k < MSG_MAX; k++) buf_q[k] <= BLANK;
         pos_q  <= '0;
         cnt_q  <= '0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
         hex_q  <= '1;
      end else begin
         if (bus.wr_en) buf_q[bus.wr_addr] <= bus.wr_data;
         if (!bus.run)    cnt_q <= '0;
         else if (expire) cnt_q <= '0;
         else             cnt_q <= cnt_q + 1'b1;
         tick_q <= bus.run & expire;
         pos_q  <= pos_d;
         wrap_q <= wrap_d;
         hex_q  <= hex_d;
      end
   end

   assign bus.hex_out = hex_q;
   assign bus.pos     = pos_q;
   assign bus.tick    = tick_q;
   assign bus.wrap    = wrap_q;
endmodule
